// File: rtl/multdiv_sequencer_pkg.sv
// Shared types and constants for the mul/div sequencer: FSM states, ALU-op codes, exception codes.
package multdiv_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_WB      = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  localparam int ALUOP_W = 5;
  localparam logic [ALUOP_W-1:0] OP_MUL = 5'b00110;
  localparam logic [ALUOP_W-1:0] OP_DIV = 5'b00111;

  localparam int RSTATUS_REG_DEF = 30;
  localparam int MUL_EXC_DEF     = 4;
  localparam int DIV_EXC_DEF     = 5;

  function automatic logic is_mul_op(input logic [ALUOP_W-1:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/md_wait_counter.sv
// WAIT-state cycle counter; tc fires combinationally in the cycle the count reaches MAX_WAIT.
// Latency: registered count, combinational terminal compare; no backpressure.
module md_wait_counter #(
  parameter int MAX_WAIT = 40,
  parameter int CNT_W    = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Compare the incremented value so exactly MAX_WAIT enabled cycles elapse before tc.
  assign tc = en && ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_WAIT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Freezes the pipeline around a multi-cycle mul/div: launch, wait for ready, write back, release.
// Latency: pulse at +1, write at +2+N; write request held until wb_grant; stall is the only combinational output.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int MAX_WAIT    = 40,
  parameter int CNT_W       = 6,
  parameter int RSTATUS_REG = RSTATUS_REG_DEF,
  parameter int MUL_EXC     = MUL_EXC_DEF,
  parameter int DIV_EXC     = DIV_EXC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dx_mul,
  input  logic              dx_div,
  input  logic [REG_W-1:0]  dx_rd,
  input  logic [DATA_W-1:0] dx_a,
  input  logic [DATA_W-1:0] dx_b,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_ready,
  input  logic              wb_grant,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  output logic              stall,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              timeout_err
);

  state_e               state_q, state_d;
  logic [ALUOP_W-1:0]   op_q, op_d;
  logic [REG_W-1:0]     rd_q, rd_d;
  logic [DATA_W-1:0]    md_a_q, md_a_d, md_b_q, md_b_d;
  logic                 md_ctrl_mult_q, md_ctrl_mult_d;
  logic                 md_ctrl_div_q, md_ctrl_div_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [REG_W-1:0]     wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]    wb_data_q, wb_data_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 cnt_clr, cnt_en, cnt_tc;

  md_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_counter (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    rd_d           = rd_q;
    md_a_d         = md_a_q;
    md_b_d         = md_b_q;
    md_ctrl_mult_d = 1'b0;
    md_ctrl_div_d  = 1'b0;
    wb_valid_d     = wb_valid_q;
    wb_reg_d       = wb_reg_q;
    wb_data_d      = wb_data_q;
    timeout_err_d  = timeout_err_q;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    stall          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall = dx_mul | dx_div;
        if (dx_mul | dx_div) begin
          op_d           = dx_mul ? OP_MUL : OP_DIV;
          rd_d           = dx_rd;
          md_a_d         = dx_a;
          md_b_d         = dx_b;
          md_ctrl_mult_d = dx_mul;
          md_ctrl_div_d  = ~dx_mul;
          state_d        = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        stall   = 1'b1;
        cnt_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        if (md_ready) begin
          if (md_exception) begin
            wb_valid_d = 1'b1;
            wb_reg_d   = REG_W'(RSTATUS_REG);
            wb_data_d  = is_mul_op(op_q) ? DATA_W'(MUL_EXC) : DATA_W'(DIV_EXC);
            state_d    = ST_WB;
          end else if (rd_q == '0) begin
            // $r0 is hardwired; nothing to write.
            state_d = ST_RELEASE;
          end else begin
            wb_valid_d = 1'b1;
            wb_reg_d   = rd_q;
            wb_data_d  = md_result;
            state_d    = ST_WB;
          end
        end else if (cnt_tc) begin
          timeout_err_d = 1'b1;
          state_d       = ST_RELEASE;
        end
      end
      ST_WB: begin
        stall = 1'b1;
        if (wb_grant) begin
          wb_valid_d = 1'b0;
          wb_reg_d   = '0;
          wb_data_d  = '0;
          state_d    = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      op_q           <= '0;
      rd_q           <= '0;
      md_a_q         <= '0;
      md_b_q         <= '0;
      md_ctrl_mult_q <= 1'b0;
      md_ctrl_div_q  <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_q       <= '0;
      wb_data_q      <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      rd_q           <= rd_d;
      md_a_q         <= md_a_d;
      md_b_q         <= md_b_d;
      md_ctrl_mult_q <= md_ctrl_mult_d;
      md_ctrl_div_q  <= md_ctrl_div_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_q       <= wb_reg_d;
      wb_data_q      <= wb_data_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign md_ctrl_mult = md_ctrl_mult_q;
  assign md_ctrl_div  = md_ctrl_div_q;
  assign md_a         = md_a_q;
  assign md_b         = md_b_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg       = wb_reg_q;
  assign wb_data      = wb_data_q;
  assign busy         = (state_q != ST_IDLE);
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: plays the multdiv unit and write-port mux, checks each operation
// against cycle/outcome expectations derived from the operand values and the latency rules.
module tb_multdiv_sequencer;

  localparam int MAX_WAIT = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        dx_mul, dx_div;
  logic [4:0]  dx_rd;
  logic [31:0] dx_a, dx_b, md_result;
  logic        md_exception, md_ready, wb_grant;
  logic        md_ctrl_mult, md_ctrl_div, stall, wb_valid, busy, timeout_err;
  logic [31:0] md_a, md_b, wb_data;
  logic [4:0]  wb_reg;

  int checks = 0;
  int errors = 0;
  bit exp_to = 1'b0;

  multdiv_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .dx_mul       (dx_mul),
    .dx_div       (dx_div),
    .dx_rd        (dx_rd),
    .dx_a         (dx_a),
    .dx_b         (dx_b),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .wb_grant     (wb_grant),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_a         (md_a),
    .md_b         (md_b),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One mul/div through the pipeline. n<0: unit never answers. gd: grant delay in WB cycles.
  // poke: present another mul in the RELEASE cycle, which must be ignored.
  task automatic run_op(input bit is_mul, input bit both, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int n, input bit exc, input int gd, input bit poke);
    bit          to, exp_wr, wb_ok;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    int          e_rel, e_wbn, pm, pd, pcyc, wbn, wb_first, rel;
    to     = (n < 0);
    exp_wr = !to && (exc || rd != 5'd0);
    e_reg  = exc ? 5'd30 : rd;
    if (exc)         e_data = is_mul ? 32'd4 : 32'd5;
    else if (is_mul) e_data = a * b;
    else             e_data = a / b;
    e_rel  = to ? 2 + MAX_WAIT : (exp_wr ? 3 + n + gd : 2 + n);
    e_wbn  = exp_wr ? gd + 1 : 0;
    if (to) exp_to = 1'b1;

    @(posedge clock); #1;
    dx_mul = is_mul; dx_div = !is_mul || both; dx_a = a; dx_b = b; dx_rd = rd;
    md_ready = 0; md_exception = 0; wb_grant = 0; md_result = 32'hdeadbeef;
    @(negedge clock);
    check("stall_decode", stall, 1);
    check("busy_decode", busy, 0);

    pm = 0; pd = 0; pcyc = -1; wbn = 0; wb_first = -1; rel = -1; wb_ok = 1;
    for (int c = 1; c < 150 && rel < 0; c++) begin
      @(posedge clock); #1;
      dx_mul = poke && (c == e_rel); dx_div = 0; dx_a = ~a; dx_b = ~b; dx_rd = 5'd31;
      md_ready     = !to && (c == 1 + n);
      md_exception = md_ready && exc;
      if (!md_ready)   md_result = 32'hdeadbeef;
      else if (is_mul) md_result = md_a * md_b;
      else             md_result = (md_b == 0) ? 32'd0 : md_a / md_b;
      wb_grant = !to && (c >= 2 + n + gd);
      @(negedge clock);
      if (md_ctrl_mult) begin pm++; pcyc = c; end
      if (md_ctrl_div)  begin pd++; pcyc = c; end
      if (c == 1) begin
        check("md_a_latched", md_a, a);
        check("md_b_latched", md_b, b);
      end
      if (wb_valid) begin
        if (wb_first < 0) wb_first = c;
        wbn++;
        if (wb_reg !== e_reg || wb_data !== e_data) wb_ok = 0;
      end
      if (!stall) begin
        rel = c;
        check("busy_release", busy, 1);
        check("timeout_err", timeout_err, exp_to);
      end
    end
    dx_mul = 0;
    check("mult_pulses", pm, is_mul ? 1 : 0);
    check("div_pulses", pd, is_mul ? 0 : 1);
    check("pulse_cycle", pcyc, 1);
    check("release_cycle", rel, e_rel);
    check("wb_cycles", wbn, e_wbn);
    if (exp_wr) begin
      check("wb_first_cycle", wb_first, 2 + n);
      check("wb_reg_data_stable", wb_ok, 1);
    end
  endtask

  initial begin
    int pm, wbn, bz;
    bit is_mul, exc;
    logic [31:0] a, b;
    logic [4:0] rd;

    reset = 1; dx_mul = 0; dx_div = 0; dx_rd = 0; dx_a = 0; dx_b = 0;
    md_result = 0; md_exception = 0; md_ready = 0; wb_grant = 0;
    @(negedge clock);
    check("rst_outputs", {md_ctrl_mult, md_ctrl_div, stall, wb_valid, busy, timeout_err}, 6'b0);
    check("rst_data", {md_a, md_b, wb_data, 27'd0, wb_reg}, 128'd0);
    @(negedge clock);
    reset = 0;

    run_op(1, 0, 32'd7, 32'd6, 5'd3, 33, 0, 0, 0);            // basic mul, 42 -> r3
    run_op(0, 0, 32'd100, 32'd0, 5'd4, 10, 1, 0, 1);          // div-by-zero -> r30 = 5
    run_op(1, 0, 32'h8000_0000, 32'd4, 5'd9, 20, 1, 1, 0);    // mul overflow -> r30 = 4
    run_op(1, 0, 32'd12, 32'd12, 5'd0, 15, 0, 0, 0);          // rd=0: no write
    run_op(0, 0, 32'd1000, 32'd7, 5'd12, 5, 0, 3, 1);         // grant held off 3 cycles
    run_op(1, 1, 32'd9, 32'd11, 5'd7, 40, 0, 0, 0);           // both decoded, ready in last WAIT cycle
    run_op(0, 0, 32'd77, 32'd3, 5'd21, 1, 0, 2, 0);           // earliest ready

    for (int i = 0; i < 8; i++) begin
      is_mul = 1'($urandom_range(0, 1));
      a      = $urandom;
      b      = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      exc    = is_mul ? ($urandom_range(0, 3) == 0) : (b == 0);
      run_op(is_mul, 0, a, b, rd, $urandom_range(1, 40), exc, $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end

    run_op(1, 0, 32'd5, 32'd5, 5'd6, -1, 0, 0, 0);            // unit never answers

    // Abort mid-WAIT with reset.
    @(posedge clock); #1;
    dx_mul = 1; dx_a = 32'd3; dx_b = 32'd4; dx_rd = 5'd8;
    @(posedge clock); #1;
    dx_mul = 0;
    repeat (10) @(posedge clock);
    #1 reset = 1;
    #1;
    check("abort_outputs", {md_ctrl_mult, md_ctrl_div, stall, wb_valid, busy, timeout_err}, 6'b0);
    check("abort_data", {md_a, md_b, wb_data, 27'd0, wb_reg}, 128'd0);
    @(negedge clock);
    reset = 0;
    exp_to = 0;
    md_ready = 1; md_result = 32'h1234; wb_grant = 1;
    pm = 0; wbn = 0; bz = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (md_ctrl_mult || md_ctrl_div) pm++;
      if (wb_valid) wbn++;
      if (busy || stall) bz++;
    end
    check("post_abort_pulses", pm, 0);
    check("post_abort_writes", wbn, 0);
    check("post_abort_busy", bz, 0);
    md_ready = 0; wb_grant = 0;

    run_op(0, 0, 32'd81, 32'd9, 5'd2, 12, 0, 0, 0);          // normal after abort

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
